// File: rtl/sleep_timer_if.sv
// Signal bundle between the nap main FSM / setting stage and the sleep countdown timer.
interface sleep_timer_if;
    logic       loadTime;
    logic [6:0] napMinutes;
    logic       enSleep;
    logic       enCancel;
    logic       completeSleep;
    logic       running;
    logic [3:0] minTens;
    logic [3:0] minOnes;
    logic [3:0] secTens;
    logic [3:0] secOnes;

    modport master (
        output loadTime, napMinutes, enSleep, enCancel,
        input  completeSleep, running, minTens, minOnes, secTens, secOnes
    );

    modport slave (
        input  loadTime, napMinutes, enSleep, enCancel,
        output completeSleep, running, minTens, minOnes, secTens, secOnes
    );
endinterface

// File: rtl/sleep_timer.sv
// Nap countdown timer: latches a clamped minute count and counts mm:ss down in BCD
// while enSleep is held, flagging completeSleep at 00:00.
module sleep_timer #(
    parameter int unsigned TICKS_PER_SEC = 1000
) (
    input logic           clock,
    input logic           reset,
    sleep_timer_if.slave  bus
);

    localparam int unsigned   PW      = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, LOADED, RUN, DONE} state_t;

    state_t        state, state_next;
    logic [PW-1:0] prescaler, prescaler_next;
    logic [3:0]    min_tens, min_ones, sec_tens, sec_ones;
    logic [3:0]    min_tens_next, min_ones_next, sec_tens_next, sec_ones_next;
    logic          paused, paused_next;
    logic          running_q, running_next;
    logic          complete_q, complete_next;
    logic          step;

    logic [6:0]    clamped, tens7, ones7;
    logic [3:0]    dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;
    logic          dec_zero;

    always_comb begin
        clamped = bus.napMinutes;
        if (bus.napMinutes == 7'd0)
            clamped = 7'd1;
        else if (bus.napMinutes > 7'd99)
            clamped = 7'd99;
        tens7 = clamped / 7'd10;
        ones7 = clamped % 7'd10;
    end

    // One-second BCD decrement with borrow chain; only used while the count is above 00:00.
    always_comb begin
        dec_min_tens = min_tens;
        dec_min_ones = min_ones;
        dec_sec_tens = sec_tens;
        dec_sec_ones = sec_ones;
        if (sec_ones != 4'd0) begin
            dec_sec_ones = sec_ones - 4'd1;
        end else begin
            dec_sec_ones = 4'd9;
            if (sec_tens != 4'd0) begin
                dec_sec_tens = sec_tens - 4'd1;
            end else begin
                dec_sec_tens = 4'd5;
                if (min_ones != 4'd0) begin
                    dec_min_ones = min_ones - 4'd1;
                end else begin
                    dec_min_ones = 4'd9;
                    dec_min_tens = min_tens - 4'd1;
                end
            end
        end
        dec_zero = (dec_min_tens == 4'd0) && (dec_min_ones == 4'd0) &&
                   (dec_sec_tens == 4'd0) && (dec_sec_ones == 4'd0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            prescaler  <= '0;
            min_tens   <= '0;
            min_ones   <= '0;
            sec_tens   <= '0;
            sec_ones   <= '0;
            paused     <= 1'b0;
            running_q  <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state      <= state_next;
            prescaler  <= prescaler_next;
            min_tens   <= min_tens_next;
            min_ones   <= min_ones_next;
            sec_tens   <= sec_tens_next;
            sec_ones   <= sec_ones_next;
            paused     <= paused_next;
            running_q  <= running_next;
            complete_q <= complete_next;
        end
    end

    always_comb begin
        state_next     = state;
        prescaler_next = prescaler;
        min_tens_next  = min_tens;
        min_ones_next  = min_ones;
        sec_tens_next  = sec_tens;
        sec_ones_next  = sec_ones;
        paused_next    = paused;
        step           = 1'b0;

        if (bus.enCancel) begin
            state_next     = IDLE;
            prescaler_next = '0;
            min_tens_next  = '0;
            min_ones_next  = '0;
            sec_tens_next  = '0;
            sec_ones_next  = '0;
            paused_next    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.loadTime) begin
                        state_next    = LOADED;
                        min_tens_next = tens7[3:0];
                        min_ones_next = ones7[3:0];
                        sec_tens_next = '0;
                        sec_ones_next = '0;
                        paused_next   = 1'b0;
                    end
                end
                LOADED: begin
                    if (bus.loadTime) begin
                        min_tens_next = tens7[3:0];
                        min_ones_next = ones7[3:0];
                        sec_tens_next = '0;
                        sec_ones_next = '0;
                        paused_next   = 1'b0;
                    end
                    if (bus.enSleep) begin
                        state_next  = RUN;
                        paused_next = 1'b0;
                        // Resuming from a pause counts this edge, so each paused cycle costs exactly one.
                        step        = paused && !bus.loadTime;
                    end
                end
                RUN: begin
                    if (!bus.enSleep) begin
                        state_next  = LOADED;
                        paused_next = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
                default: ;
            endcase

            if (step) begin
                if (prescaler == PS_LAST) begin
                    prescaler_next = '0;
                    min_tens_next  = dec_min_tens;
                    min_ones_next  = dec_min_ones;
                    sec_tens_next  = dec_sec_tens;
                    sec_ones_next  = dec_sec_ones;
                    if (dec_zero)
                        state_next = DONE;
                end else begin
                    prescaler_next = prescaler + 1'b1;
                end
            end
        end
    end

    always_comb begin
        running_next  = (state_next == RUN);
        complete_next = (state_next == DONE);
    end

    assign bus.running       = running_q;
    assign bus.completeSleep = complete_q;
    assign bus.minTens       = min_tens;
    assign bus.minOnes       = min_ones;
    assign bus.secTens       = sec_tens;
    assign bus.secOnes       = sec_ones;

endmodule

// File: tb/tb_sleep_timer.sv
// Directed self-checking bench for sleep_timer with a 4-cycle timer second.
module tb_sleep_timer;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_bad;

    sleep_timer_if bus ();

    sleep_timer #(.TICKS_PER_SEC(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] digits();
        return {bus.minTens, bus.minOnes, bus.secTens, bus.secOnes};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec          = 0;
        n_bad          = 0;
        reset          = 1'b1;
        bus.loadTime   = 1'b0;
        bus.napMinutes = 7'd0;
        bus.enSleep    = 1'b0;
        bus.enCancel   = 1'b0;

        #2 reset = 1'b0;
        #1;
        chk("rst_digits",   digits(),                16'h0000);
        chk("rst_running",  {15'd0, bus.running},       16'h0000);
        chk("rst_complete", {15'd0, bus.completeSleep}, 16'h0000);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        tick(1);

        // Load 1 minute, run uninterrupted to completion
        bus.loadTime = 1'b1; bus.napMinutes = 7'd1;
        tick(1);
        bus.loadTime = 1'b0;
        chk("load1_digits",  digits(),           16'h0100);
        chk("load1_running", {15'd0, bus.running}, 16'h0000);
        bus.enSleep = 1'b1;
        tick(1);                                  // E0
        chk("e0_running", {15'd0, bus.running}, 16'h0001);
        chk("e0_digits",  digits(),           16'h0100);
        tick(3);
        chk("e3_digits",  digits(),           16'h0100);
        tick(1);
        chk("e4_digits",  digits(),           16'h0059);
        tick(235);
        chk("e239_complete", {15'd0, bus.completeSleep}, 16'h0000);
        chk("e239_digits",   digits(),                16'h0001);
        chk("e239_running",  {15'd0, bus.running},       16'h0001);
        tick(1);
        chk("e240_complete", {15'd0, bus.completeSleep}, 16'h0001);
        chk("e240_running",  {15'd0, bus.running},       16'h0000);
        chk("e240_digits",   digits(),                16'h0000);
        bus.enSleep  = 1'b0;
        bus.enCancel = 1'b1;
        tick(1);
        bus.enCancel = 1'b0;
        chk("cancel_done_complete", {15'd0, bus.completeSleep}, 16'h0000);
        chk("cancel_done_digits",   digits(),                16'h0000);

        // Clamp, reload and BCD borrow
        bus.loadTime = 1'b1; bus.napMinutes = 7'd0;
        tick(1);
        chk("clamp0",   digits(), 16'h0100);
        bus.napMinutes = 7'd120;
        tick(1);
        chk("clamp120", digits(), 16'h9900);
        bus.napMinutes = 7'd5;
        tick(1);
        chk("reload5",  digits(), 16'h0500);
        bus.napMinutes = 7'd10;
        tick(1);
        chk("reload10", digits(), 16'h1000);
        bus.loadTime = 1'b0;
        bus.enSleep  = 1'b1;
        tick(1);                                  // E0
        tick(4);
        chk("borrow_all", digits(), 16'h0959);
        bus.loadTime = 1'b1; bus.napMinutes = 7'd3;
        tick(1);
        bus.loadTime = 1'b0;
        chk("load_in_run_digits",  digits(),           16'h0959);
        chk("load_in_run_running", {15'd0, bus.running}, 16'h0001);
        bus.enCancel = 1'b1;
        tick(1);
        bus.enCancel = 1'b0;
        bus.enSleep  = 1'b0;
        chk("cancel_run_digits",  digits(),           16'h0000);
        chk("cancel_run_running", {15'd0, bus.running}, 16'h0000);

        // Pause: 6 run cycles, 10 cycles with enSleep low, then resume
        bus.loadTime = 1'b1; bus.napMinutes = 7'd1;
        tick(1);
        bus.loadTime = 1'b0;
        bus.enSleep  = 1'b1;
        tick(1);                                  // E0
        tick(6);
        chk("pause_pre_digits", digits(), 16'h0059);
        bus.enSleep = 1'b0;
        tick(1);
        chk("pause_first_running", {15'd0, bus.running}, 16'h0000);
        chk("pause_first_digits",  digits(),           16'h0059);
        tick(9);
        chk("pause_last_digits",   digits(),           16'h0059);
        bus.enSleep = 1'b1;
        tick(1);                                  // E0+17
        chk("resume_running", {15'd0, bus.running}, 16'h0001);
        tick(232);
        chk("pause_e249_complete", {15'd0, bus.completeSleep}, 16'h0000);
        chk("pause_e249_digits",   digits(),                16'h0001);
        tick(1);
        chk("pause_e250_complete", {15'd0, bus.completeSleep}, 16'h0001);

        // DONE stickiness
        for (int i = 0; i < 20; i++) begin
            bus.enSleep    = i[0];
            bus.loadTime   = ~i[0];
            bus.napMinutes = 7'd7;
            tick(1);
            chk("done_sticky_complete", {15'd0, bus.completeSleep}, 16'h0001);
            chk("done_sticky_digits",   digits(),                16'h0000);
        end
        bus.loadTime = 1'b0;
        bus.enSleep  = 1'b0;
        bus.enCancel = 1'b1;
        tick(1);
        bus.enCancel = 1'b0;

        // Asynchronous reset mid-RUN
        bus.loadTime = 1'b1; bus.napMinutes = 7'd2;
        tick(1);
        bus.loadTime = 1'b0;
        bus.enSleep  = 1'b1;
        tick(11);
        chk("pre_rst_digits", digits(), 16'h0158);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_digits",   digits(),           16'h0000);
        chk("async_rst_running",  {15'd0, bus.running}, 16'h0000);
        chk("async_rst_complete", {15'd0, bus.completeSleep}, 16'h0000);
        bus.enSleep = 1'b0;
        #3 reset = 1'b1;
        tick(2);
        chk("post_rst_digits", digits(), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sleep_timer.md
# sleep_timer

Countdown timer that feeds `completeSleep` to the nap main state machine. It latches the nap duration chosen by the setting stage and counts it down in minutes and seconds while the main FSM holds `enSleep`. It raises `completeSleep` when the count reaches 00:00, which moves the main FSM to alarm. It also drives BCD digits of the remaining time for the display stage.

## Interface
- `TICKS_PER_SEC`, default 1000: clock cycles per timer second; legal range ≥ 2.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `loadTime`  in  1  single-cycle strobe from the setting stage; `napMinutes` is valid in the same cycle.
- `napMinutes`  in  7  nap duration in minutes, binary.
- `enSleep`  in  1  level; high while the main FSM is in sleep.
- `enCancel`  in  1  level or pulse from the main FSM; aborts and clears the timer.
- `completeSleep`  out  1  high while in DONE.
- `running`  out  1  high while in RUN.
- `minTens`, `minOnes`, `secTens`, `secOnes`  out  4 each  remaining time as BCD mm:ss.

## Operation
- State register is `state`, with states IDLE, LOADED, RUN, DONE. All outputs are registered.
- Priority on every edge: `enCancel` first, then the per-state rules below.
- `enCancel` = 1 in any state:
  - next state IDLE;
  - all digits cleared to 0;
  - prescaler cleared to 0.
- IDLE:
  - Digits read 00:00.
  - `loadTime` = 1 → LOADED, with minutes = clamp(`napMinutes`) converted to BCD and seconds = 00.
  - `enSleep` has no effect.
- Clamp rule for `napMinutes`:
  - 0 → 1;
  - 1..99 → unchanged;
  - 100..127 → 99.
- LOADED:
  - `loadTime` = 1 → reload the digits by the same rule; stay in LOADED.
  - `enSleep` = 1 → RUN. The prescaler is not reset on this transition.
  - If `loadTime` and `enSleep` are high in the same cycle, the reload applies and the state moves to RUN.
- RUN:
  - The prescaler increments each cycle.
  - When the prescaler equals TICKS_PER_SEC−1 it wraps to 0 and the mm:ss count decrements by one second.
  - BCD decrement rules:
    - `secOnes` 0 → 9 with a borrow into `secTens`;
    - `secTens` 0 → 5 with a borrow into `minOnes`;
    - `minOnes` 0 → 9 with a borrow into `minTens`.
  - The decrement that produces 00:00 also moves the state to DONE on the same edge.
  - `enSleep` = 0 → LOADED (pause). Digits and prescaler hold their values; no decrement happens on that edge.
  - `loadTime` is ignored.
- DONE:
  - Digits hold 00:00 and `completeSleep` = 1.
  - `loadTime` and `enSleep` are ignored.
  - Only `enCancel` or `reset` leaves DONE.
- Digits never take non-BCD values and the count never goes below 00:00.
- The prescaler width is ceil(log2(TICKS_PER_SEC)).

## Timing
- Reset values:
  - state IDLE;
  - prescaler 0;
  - all digits 0;
  - `completeSleep` = 0;
  - `running` = 0.
- Reset asserted mid-RUN or in DONE forces these values immediately, without waiting for a clock edge.
- Load latency: the digits show the loaded value in the cycle after the `loadTime` edge.
- Run latency: let E0 be the edge that samples `enSleep` = 1 in LOADED and `running` rises after E0.
  - With no pause, the first decrement occurs at edge E0+TICKS_PER_SEC.
  - `completeSleep` rises after edge E0 + N·60·TICKS_PER_SEC, where N is the clamped minute count.
- Pause: every cycle with `enSleep` = 0 extends the completion time by exactly one cycle. The partial second is preserved across the pause.
- `completeSleep` stays high for every cycle until `enCancel` or reset. It falls in the cycle after the edge that samples `enCancel` = 1.
- `running` falls on the same edge as the RUN → DONE, RUN → LOADED, or cancel transition.

## Test plan
- Reset, load 1 min, run uninterrupted (TICKS_PER_SEC=4), then cancel:
  - stimulus: `reset` low then high; `loadTime` with `napMinutes` = 1; `enSleep` = 1 held high;
  - required: digits read 01:00 one cycle after the load; 00:59 after edge E0+4; `completeSleep` = 1 after edge E0+240 (and not at E0+239); digits 00:00;
  - then `enCancel` pulse → IDLE; `completeSleep` = 0 next cycle.
- Clamp, BCD borrow and reload:
  - `napMinutes` = 0 loads 01:00; `napMinutes` = 120 loads 99:00;
  - `napMinutes` = 10, run one second → 09:59 (borrow through all digits);
  - `loadTime` with 5 while in LOADED → 05:00;
  - `loadTime` during RUN → no change to the digits.
- Pause: load 1 min (TICKS_PER_SEC=4), run 6 cycles, drop `enSleep` for 10 cycles, then resume → `completeSleep` rises after edge E0+250; digits frozen during the pause.
- Cancel and reset in flight:
  - `enCancel` mid-RUN → IDLE, 00:00, `running` = 0 next cycle;
  - async `reset` low mid-RUN (between edges) → outputs at reset values immediately.
- DONE stickiness: in DONE, toggle `enSleep` and pulse `loadTime` for 20 cycles → `completeSleep` stays 1 and digits stay 00:00 throughout.
